// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: FSM state encoding and the
// scan-code prefixes that the receiver can fold into key-event flags.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

endpackage

// File: rtl/ps2_frame_receiver_sync_edge.sv
// Synchronizes the asynchronous PS/2 clock and data lines and produces a
// one-cycle falling-edge pulse on ps2_clk with a data sample aligned to it.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_pulse,
  output logic data_sync
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_chain;
  logic                   clk_prev;

  // Synchronizer chains; reset to 1 so a released reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync   <= '1;
      data_chain <= '1;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_chain <= {data_chain[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Registered falling-edge detect; data is registered alongside so both line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev   <= 1'b1;
      fall_pulse <= 1'b0;
      data_sync  <= 1'b1;
    end else begin
      clk_prev   <= clk_sync[SYNC_STAGES-1];
      fall_pulse <= clk_prev & ~clk_sync[SYNC_STAGES-1];
      data_sync  <= data_chain[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start/data/parity/stop framing checks,
// stalled-frame watchdog, and optional E0/F0 prefix folding into key flags.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DECODE_PREFIX  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [DATA_BITS-1:0] key_out,
  output logic                 key_valid,
  output logic                 extended,
  output logic                 released,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]     LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic [WD_W-1:0]      WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_BITS-1:0] EXT_CODE  = DATA_BITS'(PS2_EXT_PREFIX);
  localparam logic [DATA_BITS-1:0] BRK_CODE  = DATA_BITS'(PS2_BRK_PREFIX);
  localparam bit                   DECODE_EN = (DECODE_PREFIX != 0);

  logic                 fall_pulse;
  logic                 data_sync;
  ps2_state_e           state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic [WD_W-1:0]      wd_cnt;
  logic                 wd_expire;
  logic                 ext_pending;
  logic                 rel_pending;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fall_pulse(fall_pulse),
    .data_sync (data_sync)
  );

  // An edge on the expiry cycle takes precedence, so the watchdog only fires without one.
  assign wd_expire = (state != IDLE) && !fall_pulse && (wd_cnt == WD_LAST);

  // Watchdog: restarts on every PS/2 edge, runs only while a frame is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (fall_pulse || state == IDLE) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_LAST) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // Frame FSM, error strobes and prefix folding, all advanced by PS/2 falling edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      parity_bit  <= 1'b0;
      ext_pending <= 1'b0;
      rel_pending <= 1'b0;
      key_out     <= '0;
      key_valid   <= 1'b0;
      extended    <= 1'b0;
      released    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
      if (wd_expire) begin
        state       <= IDLE;
        timeout_err <= 1'b1;
        ext_pending <= 1'b0;
        rel_pending <= 1'b0;
      end else if (fall_pulse) begin
        case (state)
          IDLE: begin
            if (!data_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err   <= 1'b1;
              ext_pending <= 1'b0;
              rel_pending <= 1'b0;
            end
          end
          DATA: begin
            shift   <= {data_sync, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_sync;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!data_sync) begin
              frame_err   <= 1'b1;
              ext_pending <= 1'b0;
              rel_pending <= 1'b0;
            end else if (!(^{shift, parity_bit})) begin
              // Odd parity: data bits plus parity bit must XOR to 1.
              parity_err  <= 1'b1;
              ext_pending <= 1'b0;
              rel_pending <= 1'b0;
            end else if (DECODE_EN && shift == EXT_CODE) begin
              ext_pending <= 1'b1;
            end else if (DECODE_EN && shift == BRK_CODE) begin
              rel_pending <= 1'b1;
            end else begin
              key_out     <= shift;
              key_valid   <= 1'b1;
              extended    <= ext_pending;
              released    <= rel_pending;
              ext_pending <= 1'b0;
              rel_pending <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: directed scenarios plus a
// randomized frame stream checked against a scan-code level reference model.
`timescale 1ns/1ps
module tb_ps2_frame_receiver;

  localparam int SYNC = 2;
  localparam int TO   = 100;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  logic [7:0] key_out, key_out_r;
  logic key_valid, extended, released, frame_err, parity_err, timeout_err;
  logic key_valid_r, extended_r, released_r, frame_err_r, parity_err_r, timeout_err_r;

  always #5 clk = ~clk;

  ps2_frame_receiver #(
    .DATA_BITS(8), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .DECODE_PREFIX(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_out(key_out), .key_valid(key_valid), .extended(extended), .released(released),
    .frame_err(frame_err), .parity_err(parity_err), .timeout_err(timeout_err)
  );

  ps2_frame_receiver #(
    .DATA_BITS(8), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .DECODE_PREFIX(0)
  ) dut_raw (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_out(key_out_r), .key_valid(key_valid_r), .extended(extended_r), .released(released_r),
    .frame_err(frame_err_r), .parity_err(parity_err_r), .timeout_err(timeout_err_r)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events: {key_out, extended, released}
  logic [9:0] obs_q[$];
  logic [9:0] obs_raw_q[$];
  int n_fe, n_pe, n_to;
  int unsigned kv_cyc, to_cyc, last_fall;

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        obs_q.push_back({key_out, extended, released});
        kv_cyc = cyc;
      end
      if (key_valid_r) obs_raw_q.push_back({key_out_r, extended_r, released_r});
      if (frame_err) n_fe++;
      if (parity_err) n_pe++;
      if (timeout_err) begin
        n_to++;
        to_cyc = cyc;
      end
    end
  end

  // Reference model at scan-code level
  bit m_ext, m_rel;
  logic [9:0] exp_q[$];
  logic [9:0] exp_raw_q[$];
  int e_fe, e_pe;

  task automatic model_frame(input logic [7:0] b, input bit bp, input bit bs);
    if (bs) begin
      e_fe++; m_ext = 0; m_rel = 0;
    end else if (bp) begin
      e_pe++; m_ext = 0; m_rel = 0;
    end else begin
      exp_raw_q.push_back({b, 2'b00});
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_rel = 1;
      else begin
        exp_q.push_back({b, m_ext, m_rel});
        m_ext = 0; m_rel = 0;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete(); obs_raw_q.delete();
    n_fe = 0; n_pe = 0; n_to = 0;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bp, input bit bs);
    logic par;
    par = (~^b) ^ bp;
    return {~bs, par, b, 1'b0};
  endfunction

  // Device-side waveform: data changes while clock is high, host samples on fall.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      tick(HALF);
      ps2_clk = 1'b0;
      last_fall = cyc;
      tick(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs);
    send_bits(frame_bits(b, bp, bs), 11);
    ps2_data = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if (key_out !== 8'h00) begin errors++; $display("FAIL reset_key_out: got %h expected 00", key_out); end
    checks++;
    if ({key_valid, extended, released, frame_err, parity_err, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {key_valid, extended, released, frame_err, parity_err, timeout_err});
    end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_basic();
    clear_obs();
    send_frame(8'h1C, 0, 0);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0] !== {8'h1C, 2'b00}) begin errors++; $display("FAIL basic_event: got %h expected %h", obs_q[0], {8'h1C, 2'b00}); end
    end
    checks++;
    if (kv_cyc - last_fall != SYNC + 2) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", kv_cyc - last_fall, SYNC + 2); end
    checks++;
    if (n_fe + n_pe + n_to != 0) begin errors++; $display("FAIL basic_noerr: got %0d expected 0", n_fe + n_pe + n_to); end
    tick(10);
    checks++;
    if (key_out !== 8'h1C) begin errors++; $display("FAIL basic_hold: got %h expected 1c", key_out); end
  endtask

  task automatic test_prefix();
    clear_obs();
    send_frame(8'hF0, 0, 0);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL prefix_f0_silent: got %0d expected 0", obs_q.size()); end
    send_frame(8'h1C, 0, 0);
    checks++;
    if (obs_q.size() != 1 || obs_q[obs_q.size()-1] !== {8'h1C, 2'b01}) begin
      errors++; $display("FAIL prefix_break: got %0d events last %h expected 1 events %h", obs_q.size(), obs_q[obs_q.size()-1], {8'h1C, 2'b01});
    end
    clear_obs();
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    checks++;
    if (obs_q.size() != 1 || obs_q[obs_q.size()-1] !== {8'h75, 2'b11}) begin
      errors++; $display("FAIL prefix_ext_break: got %0d events last %h expected 1 events %h", obs_q.size(), obs_q[obs_q.size()-1], {8'h75, 2'b11});
    end
  endtask

  task automatic test_parity_err();
    clear_obs();
    send_frame(8'hE0, 0, 0);
    send_frame(8'h1C, 1, 0);
    checks++;
    if (n_pe != 1 || n_fe != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL parity_err: got pe=%0d fe=%0d ev=%0d expected pe=1 fe=0 ev=0", n_pe, n_fe, obs_q.size());
    end
    send_frame(8'h1C, 0, 0);
    checks++;
    if (obs_q.size() != 1 || obs_q[obs_q.size()-1] !== {8'h1C, 2'b00}) begin
      errors++; $display("FAIL parity_recover: got %0d events last %h expected 1 events %h", obs_q.size(), obs_q[obs_q.size()-1], {8'h1C, 2'b00});
    end
  endtask

  task automatic test_frame_err();
    clear_obs();
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 1);
    checks++;
    if (n_fe != 1 || n_pe != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL stop_err: got fe=%0d pe=%0d ev=%0d expected fe=1 pe=0 ev=0", n_fe, n_pe, obs_q.size());
    end
    send_bits(11'h001, 1);
    ps2_data = 1'b1;
    tick(2 * HALF);
    checks++;
    if (n_fe != 2 || obs_q.size() != 0) begin
      errors++; $display("FAIL start_err: got fe=%0d ev=%0d expected fe=2 ev=0", n_fe, obs_q.size());
    end
    send_frame(8'h1C, 0, 0);
    checks++;
    if (obs_q.size() != 1 || obs_q[obs_q.size()-1] !== {8'h1C, 2'b00}) begin
      errors++; $display("FAIL frame_recover: got %0d events last %h expected 1 events %h", obs_q.size(), obs_q[obs_q.size()-1], {8'h1C, 2'b00});
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    send_frame(8'hE0, 0, 0);
    send_bits(frame_bits(8'h29, 0, 0), 5);
    for (int i = 0; i < 400 && n_to == 0; i++) tick(1);
    checks++;
    if (n_to != 1) begin errors++; $display("FAIL timeout_fired: got %0d expected 1", n_to); end
    else begin
      checks++;
      if (to_cyc - last_fall != SYNC + 2 + TO) begin
        errors++; $display("FAIL timeout_delay: got %0d expected %0d", to_cyc - last_fall, SYNC + 2 + TO);
      end
    end
    ps2_data = 1'b1;
    tick(10);
    send_frame(8'h29, 0, 0);
    checks++;
    if (obs_q.size() != 1 || obs_q[obs_q.size()-1] !== {8'h29, 2'b00} || n_fe != 0 || n_pe != 0) begin
      errors++; $display("FAIL timeout_recover: got %0d events last %h fe=%0d pe=%0d expected 1 events %h", obs_q.size(), obs_q[obs_q.size()-1], n_fe, n_pe, {8'h29, 2'b00});
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bp, bs;
    int r;
    clear_obs();
    exp_q.delete(); exp_raw_q.delete();
    e_fe = 0; e_pe = 0; m_ext = 0; m_rel = 0;
    for (int f = 0; f < 30; f++) begin
      r = $urandom_range(0, 9);
      b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 7) == 0);
      model_frame(b, bp, bs);
      send_frame(b, bp, bs);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_event[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
    end
    checks++;
    if (obs_raw_q.size() != exp_raw_q.size()) begin
      errors++; $display("FAIL rand_raw_count: got %0d expected %0d", obs_raw_q.size(), exp_raw_q.size());
    end else begin
      for (int i = 0; i < exp_raw_q.size(); i++) begin
        checks++;
        if (obs_raw_q[i] !== exp_raw_q[i]) begin errors++; $display("FAIL rand_raw_event[%0d]: got %h expected %h", i, obs_raw_q[i], exp_raw_q[i]); end
      end
    end
    checks++;
    if (n_fe != e_fe || n_pe != e_pe || n_to != 0) begin
      errors++; $display("FAIL rand_errs: got fe=%0d pe=%0d to=%0d expected fe=%0d pe=%0d to=0", n_fe, n_pe, n_to, e_fe, e_pe);
    end
  endtask

  task automatic test_reset_midframe();
    clear_obs();
    send_frame(8'hE0, 0, 0);
    send_bits(frame_bits(8'h1C, 0, 0), 3);
    rst_n = 1'b0;
    #2;
    checks++;
    if (key_out !== 8'h00 || key_out_r !== 8'h00 || {key_valid, extended, released, frame_err, parity_err, timeout_err} !== 6'b0) begin
      errors++; $display("FAIL async_reset: got key=%h raw=%h flags=%b expected 00 00 000000", key_out, key_out_r,
                         {key_valid, extended, released, frame_err, parity_err, timeout_err});
    end
    ps2_data = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    clear_obs();
    send_frame(8'h1C, 0, 0);
    checks++;
    if (obs_q.size() != 1 || obs_q[obs_q.size()-1] !== {8'h1C, 2'b00}) begin
      errors++; $display("FAIL reset_clears_ext: got %0d events last %h expected 1 events %h", obs_q.size(), obs_q[obs_q.size()-1], {8'h1C, 2'b00});
    end
    send_frame(8'hE0, 0, 0);
    checks++;
    if (obs_raw_q.size() != 2 || obs_raw_q[obs_raw_q.size()-1] !== {8'hE0, 2'b00}) begin
      errors++; $display("FAIL raw_e0: got %0d events last %h expected 2 events %h", obs_raw_q.size(), obs_raw_q[obs_raw_q.size()-1], {8'hE0, 2'b00});
    end
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL decoded_e0_silent: got %0d expected 1", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_parity_err();
    test_frame_err();
    test_timeout();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1, "time limit reached");
  end

endmodule
